// File: rtl/qconv_ihw_low_pkg.sv
// qconv_ihw_low_pkg
//   Shared constants and types for the ihw_low loop stage of the qconv state
//   hierarchy: default tile/kernel geometry, address widths, credit limit and
//   the stage FSM encoding.
package qconv_ihw_low_pkg;

    localparam int TILE_H       = 4;  // output tile rows
    localparam int TILE_W       = 4;  // output tile cols
    localparam int K_MAX        = 3;  // largest kernel edge
    localparam int K_BW         = 2;  // kh/kw width
    localparam int IN_AW        = 6;  // input-buffer address width
    localparam int OUT_AW       = 4;  // accumulator address width
    localparam int MAX_INFLIGHT = 4;  // issued-but-unacked request limit

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ihw_state_t;

endpackage

// File: rtl/qconv_ihw_low_if.sv
// qconv_ihw_low_if
//   MAC request link between the ihw_low stage (master) and the MAC datapath
//   (slave).
//   mac_valid/mac_ready : request handshake, transfer when both high
//   in_addr/out_addr    : input-buffer and accumulator addresses of the pixel
//   mac_first/mac_last  : request is pixel (0,0) / the final pixel of the pass
//   acc_done            : one-cycle writeback ack, one per accepted request
interface qconv_ihw_low_if #(
    parameter int InAddrW  = qconv_ihw_low_pkg::IN_AW,
    parameter int OutAddrW = qconv_ihw_low_pkg::OUT_AW
);
    logic                mac_valid;
    logic                mac_ready;
    logic [InAddrW-1:0]  in_addr;
    logic [OutAddrW-1:0] out_addr;
    logic                mac_first;
    logic                mac_last;
    logic                acc_done;

    modport master (
        output mac_valid, in_addr, out_addr, mac_first, mac_last,
        input  mac_ready, acc_done
    );

    modport slave (
        input  mac_valid, in_addr, out_addr, mac_first, mac_last,
        output mac_ready, acc_done
    );
endinterface

// File: rtl/qconv_credit_counter.sv
// qconv_credit_counter
//   Tracks issued-but-unacknowledged requests. Shared by the loop stages that
//   talk to the MAC.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : a request was accepted this cycle
//   dec        : an ack arrived this cycle
//   full       : count == MaxCount, no further issue allowed
//   drained    : count will be zero after this edge
//   underflow  : ack arrived with nothing outstanding (ack is dropped)
module qconv_credit_counter #(
    parameter int MaxCount = qconv_ihw_low_pkg::MAX_INFLIGHT,
    parameter int CntW     = $clog2(MaxCount + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic drained,
    output logic underflow
);
    logic [CntW-1:0] cnt, cnt_nxt;
    logic            empty, dec_ok;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CntW'(MaxCount));
    assign underflow = dec && empty;
    // An ack against an empty counter carries no request, so it is ignored.
    assign dec_ok    = dec && !empty;

    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec_ok)
            cnt_nxt = cnt + CntW'(1);
        else if (!inc && dec_ok)
            cnt_nxt = cnt - CntW'(1);
    end

    // Looking at the next value lets the parent finish the cycle after the
    // last ack instead of one cycle later.
    assign drained = (cnt_nxt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nxt;
    end
endmodule

// File: rtl/qconv_ihw_low.sv
// qconv_ihw_low
//   Innermost qconv loop: for the (kh,kw) handed over by the khw loop, walks
//   every output pixel of the tile row-major and issues one MAC request per
//   pixel, bounded by MaxInflight outstanding requests. finish pulses once all
//   issued requests have been acknowledged.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle start pulse, honoured only when idle
//   kh, kw     : kernel offsets, captured on an accepted start
//   busy       : stage is not idle
//   finish     : one-cycle pass-complete pulse
//   err        : sticky; stray ack or out-of-range kh/kw at start
//   mac        : MAC request/ack link (master side)
module qconv_ihw_low
    import qconv_ihw_low_pkg::*;
#(
    parameter int TileH       = TILE_H,
    parameter int TileW       = TILE_W,
    parameter int KMax        = K_MAX,
    parameter int KBitWidth   = K_BW,
    parameter int InAddrW     = IN_AW,
    parameter int OutAddrW    = OUT_AW,
    parameter int MaxInflight = MAX_INFLIGHT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KBitWidth-1:0] kh,
    input  logic [KBitWidth-1:0] kw,
    output logic                 busy,
    output logic                 finish,
    output logic                 err,
    qconv_ihw_low_if.master      mac
);
    // Input tile row pitch (output tile widened by the kernel halo).
    localparam int InW = TileW + KMax - 1;

    ihw_state_t           state, state_nxt;
    logic [KBitWidth-1:0] kh_q, kw_q;
    logic [OutAddrW-1:0]  ih, iw;
    logic                 full, drained, underflow;
    logic                 issue_ok, accept, last_pix, row_end;

    qconv_credit_counter #(.MaxCount(MaxInflight)) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (accept),
        .dec       (mac.acc_done),
        .full      (full),
        .drained   (drained),
        .underflow (underflow)
    );

    assign issue_ok = (state == ISSUE) && !full;
    assign accept   = issue_ok && mac.mac_ready;
    assign row_end  = (iw == OutAddrW'(TileW - 1));
    assign last_pix = (ih == OutAddrW'(TileH - 1)) && row_end;
    assign busy     = (state != IDLE);

    // Request fields come straight from the registered counters, so they hold
    // still for as long as the MAC stalls.
    assign mac.mac_valid = issue_ok;
    assign mac.in_addr   = (InAddrW'(ih) + InAddrW'(kh_q)) * InAddrW'(InW)
                         + InAddrW'(iw) + InAddrW'(kw_q);
    assign mac.out_addr  = ih * OutAddrW'(TileW) + iw;
    assign mac.mac_first = issue_ok && (ih == '0) && (iw == '0);
    assign mac.mac_last  = issue_ok && last_pix;

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (accept && last_pix) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = DONE;
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            kh_q  <= '0;
            kw_q  <= '0;
            ih    <= '0;
            iw    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (underflow) err <= 1'b1;
            if (state == IDLE && start) begin
                kh_q <= kh;
                kw_q <= kw;
                ih   <= '0;
                iw   <= '0;
                if (32'(kh) >= KMax || 32'(kw) >= KMax) err <= 1'b1;
            end else if (accept) begin
                if (row_end) begin
                    iw <= '0;
                    ih <= ih + OutAddrW'(1);
                end else begin
                    iw <= iw + OutAddrW'(1);
                end
            end
        end
    end
endmodule
